mmm_lane_scheduler: RTL and testbench
=====================================

# mmm_lane_scheduler

Control sequencer for a P-lane matrix-multiply datapath. It drives the input-memory read ports (one A address, P B addresses), issues lockstep valid/clear strobes to P MAC lanes that compute P adjacent output columns at once, and drains the P lane results into the output FIFO one per cycle under FIFO-capacity backpressure. It sits between `input_mems_buffer`, the MAC lanes and `fifo_out`, and handshakes matrix completion back to the input memory.

## Interface
- `INW`, 12: operand width (used only for documentation of lane widths)
- `OUTW`, 32: lane result / FIFO data width
- `M`, 7: rows of A / output
- `N`, 9: columns of B / output; must be a multiple of `P`
- `MAXK`, 8: maximum inner dimension
- `P`, 3: number of parallel MAC lanes
- `PIPE`, 3: cycles from an address beat to the matching lane accumulate (memory read plus MAC input stages)
- `clk`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `matrices_loaded`  in  1  level; A and B are resident in the input memory
- `K`  in  $clog2(MAXK+1)  inner dimension; sampled on IDLE→ISSUE
- `compute_finished`  out  1  one-cycle pulse, whole output matrix written
- `A_read_addr`  out  $clog2(M*MAXK)  A memory read address
- `B_read_addr`  out  P*$clog2(MAXK*N)  lane l uses slice l
- `lane_valid`  out  1  accumulate strobe, shared by all lanes
- `lane_clear`  out  1  with `lane_valid`: load the product instead of adding it
- `lane_data`  in  P*OUTW  lane accumulators, lane l in slice l
- `fifo_capacity`  in  $clog2(N+1)  free FIFO slots
- `fifo_wr_en`  out  1  FIFO write strobe
- `fifo_data`  out  OUTW  FIFO write data
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, FLUSH, DRAIN, DONE.
- **Counters.** Row `r` counts 0..M-1. Column group `g` counts 0..N/P-1. Beat `k` counts 0..Kr-1, where Kr is the latched K. Flush counter `f` counts 0..PIPE. Drain lane `d` counts 0..P-1.
- **IDLE.**
  - Counters are zero.
  - Go to ISSUE when `matrices_loaded`=1 and the previous state was not DONE.
  - Latch K into Kr on that transition.
  - If K=0, go to DONE instead; no writes are produced.
- **ISSUE.** One beat per cycle, k = 0..Kr-1.
  - `A_read_addr` = r*Kr + k.
  - `B_read_addr[l]` = k*N + g*P + l.
  - Both are combinational from registered counters.
  - Addresses are generated incrementally: an A base advances by Kr per row, a B base advances by N per beat. No multipliers.
  - After beat Kr-1, go to FLUSH.
- **Addresses outside ISSUE.** Both are 0.
- **FLUSH.** Wait PIPE+1 cycles (f=0..PIPE) so every lane accumulator holds its final sum, then go to DRAIN with d=0.
- **DRAIN.**
  - `fifo_data` = `lane_data[d]`.
  - `fifo_wr_en` = (`fifo_capacity` != 0), combinational.
  - d advances only on a write.
  - After the write of lane P-1:
    - if g < N/P-1: g+1, same r, go to ISSUE;
    - else if r < M-1: g=0, r+1, go to ISSUE;
    - else go to DONE.
- **DONE.**
  - `compute_finished`=1 for exactly this one cycle.
  - Next state is IDLE.
  - `matrices_loaded` is ignored in the first IDLE cycle after DONE.
- **Output order.** Row-major: r, then g, then lane.
- **Reset.** From any state, reset returns to IDLE with all counters cleared. A partially accumulated group is abandoned; no write follows reset.

## Timing
- **Reset values.** All outputs are 0 in the cycle after reset: `compute_finished`, `lane_valid`, `lane_clear`, `fifo_wr_en`, `busy`, addresses, `fifo_data` (lane_data[0] is gated to 0 outside DRAIN).
- **Strobe alignment.** A beat presented on the addresses in cycle t produces `lane_valid`=1 in cycle t+PIPE. `lane_clear`=1 in that same cycle iff k=0. This uses a PIPE-deep shift register of {valid, clear}.
- **Strobes outside ISSUE.** Valid and clear are 0 for beats not in ISSUE. The shift register is cleared on reset.
- **Group cost.** Kr + (PIPE+1) + P cycles with no backpressure.
- **Matrix cost.** First ISSUE cycle to DONE is (M*N/P)*(Kr+PIPE+1+P) cycles. `compute_finished` occurs 1 cycle after the final write.
- **Backpressure.**
  - `fifo_capacity`=0 in DRAIN holds d and `fifo_data`, with `fifo_wr_en`=0.
  - ISSUE and FLUSH never stall.
  - The writer never exceeds capacity, because capacity is re-read every cycle.
- **Simultaneous events.** `matrices_loaded` falling during ISSUE, FLUSH or DRAIN is ignored; the matrix completes.

## Test plan
- **Reset mid-ISSUE.** Reset at k=1 of r=0, g=0 → next cycle state is IDLE and all outputs are 0. The bench checks that no `fifo_wr_en` occurs and no stray `lane_valid` appears PIPE cycles later.
- **Free-running matrix.** M=7, N=9, P=3, PIPE=3, K=2, capacity held at 9 → exactly 63 writes in row-major order. `compute_finished` pulses once, 21*9=189 cycles after the first ISSUE cycle.
- **Address pattern.** K=3, during r=1, g=2 → `A_read_addr` reads 3, 4, 5. `B_read_addr[0]` reads 6, 15, 24; lane 2 reads 8, 17, 26. `lane_clear` is high only on the beat that lands PIPE cycles after k=0.
- **Stalled drain.** Capacity forced to 0 for 5 cycles at d=1 → `fifo_wr_en` stays 0 and `fifo_data` is stable. The next write is lane 1, with no duplicate or skipped lane.
- **Randomized capacity.** Random `fifo_capacity` in {0, 1, 2} with K=8 and random signed operands → the scoreboard matches a golden A×B over all 63 results, and no write ever occurs with capacity 0.
- **K=0.** `matrices_loaded`=1 with K=0 → DONE on the next cycle and a single `compute_finished` pulse. No `lane_valid` and no `fifo_wr_en` occur.

Source files
------------

// File: rtl/mmm_lane_scheduler.sv
// mmm_lane_scheduler: sequences a P-lane matrix multiply. It walks rows and
// column groups, issues K address beats per group, waits for the lane
// pipeline to settle, then drains the P lane results into the output FIFO.

// Per-lane B address: lane l reads column g*P + l of the current B row.
module mmm_lane_addr #(
  parameter int BW   = 7,
  parameter int LANE = 0
) (
  input  logic          issue,
  input  logic [BW-1:0] base,
  output logic [BW-1:0] addr
);
  // Offset the shared row/group base by this lane's column; 0 when not issuing.
  always_comb addr = issue ? base + BW'(LANE) : '0;
endmodule

module mmm_lane_scheduler #(
  parameter int INW  = 12,
  parameter int OUTW = 32,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  parameter int P    = 3,
  parameter int PIPE = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           matrices_loaded,
  input  logic [$clog2(MAXK+1)-1:0]      K,
  output logic                           compute_finished,
  output logic [$clog2(M*MAXK)-1:0]      A_read_addr,
  output logic [P*$clog2(MAXK*N)-1:0]    B_read_addr,
  output logic                           lane_valid,
  output logic                           lane_clear,
  input  logic [P*OUTW-1:0]              lane_data,
  input  logic [$clog2(N+1)-1:0]         fifo_capacity,
  output logic                           fifo_wr_en,
  output logic [OUTW-1:0]                fifo_data,
  output logic                           busy
);
  localparam int KW = $clog2(MAXK+1);
  localparam int AW = $clog2(M*MAXK);
  localparam int BW = $clog2(MAXK*N);
  localparam int G  = N / P;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int FW = (PIPE > 0) ? $clog2(PIPE+1) : 1;
  localparam int DW = (P > 1) ? $clog2(P) : 1;

  // Column groups must tile N exactly, and a lane must hold a full K-deep sum.
  if (N % P != 0 || OUTW < 2*INW + $clog2(MAXK)) begin : g_bad_params
    $error("mmm_lane_scheduler: N must be a multiple of P and OUTW must hold a MAXK-deep sum");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, FLUSH, DRAIN, DONE} state_t;
  state_t state, state_n;

  logic [RW-1:0] r;
  logic [GW-1:0] g;
  logic [KW-1:0] k, kr;
  logic [FW-1:0] f;
  logic [DW-1:0] d;
  logic [AW-1:0] a_base;
  logic [BW-1:0] b_base, g_off, b_lane_base;
  logic          was_done;
  logic [PIPE-1:0] vld_pipe, clr_pipe;
  logic [P-1:0][OUTW-1:0] lanes;

  logic start, issue, last_beat, flush_end, last_lane, last_g, last_r;

  assign lanes       = lane_data;
  assign start       = (state == IDLE) && matrices_loaded && !was_done;
  assign last_beat   = (k == kr - KW'(1));
  assign flush_end   = (f == FW'(PIPE));
  assign last_lane   = (d == DW'(P-1));
  assign last_g      = (g == GW'(G-1));
  assign last_r      = (r == RW'(M-1));
  assign b_lane_base = b_base + g_off;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_n          = state;
    issue            = 1'b0;
    fifo_wr_en       = 1'b0;
    compute_finished = 1'b0;
    busy             = (state != IDLE);
    case (state)
      IDLE:  if (start) state_n = (K == '0) ? DONE : ISSUE;
      ISSUE: begin
        issue = 1'b1;
        if (last_beat) state_n = FLUSH;
      end
      FLUSH: if (flush_end) state_n = DRAIN;
      DRAIN: begin
        fifo_wr_en = (fifo_capacity != '0);
        if (fifo_wr_en && last_lane) state_n = (last_g && last_r) ? DONE : ISSUE;
      end
      DONE: begin
        compute_finished = 1'b1;
        state_n          = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Walk r/g/k/f/d; address bases advance by adds so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0; g <= '0; k <= '0; f <= '0; d <= '0; kr <= '0;
      a_base <= '0; b_base <= '0; g_off <= '0; was_done <= 1'b0;
    end else begin
      was_done <= (state == DONE);
      case (state)
        IDLE: if (start) kr <= K;
        ISSUE: begin
          if (last_beat) begin
            k <= '0; b_base <= '0; f <= '0;
          end else begin
            k <= k + KW'(1); b_base <= b_base + BW'(N);
          end
        end
        FLUSH: begin
          f <= flush_end ? '0 : f + FW'(1);
          d <= '0;
        end
        DRAIN: if (fifo_wr_en) begin
          if (!last_lane) d <= d + DW'(1);
          else begin
            d <= '0;
            if (!last_g) begin
              g <= g + GW'(1); g_off <= g_off + BW'(P);
            end else if (!last_r) begin
              g <= '0; g_off <= '0; r <= r + RW'(1); a_base <= a_base + AW'(kr);
            end
          end
        end
        DONE: begin
          r <= '0; g <= '0; k <= '0; f <= '0; d <= '0;
          a_base <= '0; b_base <= '0; g_off <= '0;
        end
        default: ;
      endcase
    end
  end

  // Delay each beat's {valid, clear} to the cycle its operands reach the lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      clr_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | PIPE'(issue);
      clr_pipe <= (clr_pipe << 1) | PIPE'(issue && (k == '0));
    end
  end

  assign lane_valid  = vld_pipe[PIPE-1];
  assign lane_clear  = clr_pipe[PIPE-1];
  assign A_read_addr = issue ? a_base + AW'(k) : '0;
  assign fifo_data   = (state == DRAIN) ? lanes[d] : '0;

  for (genvar l = 0; l < P; l++) begin : g_lane
    mmm_lane_addr #(.BW(BW), .LANE(l)) u_addr (
      .issue(issue),
      .base (b_lane_base),
      .addr (B_read_addr[l*BW +: BW])
    );
  end
endmodule

// File: tb/tb_mmm_lane_scheduler.sv
// Bench for mmm_lane_scheduler: models input memories and MAC lanes around
// the DUT, predicts C = A x B in row-major order and scoreboards FIFO writes.
module tb_mmm_lane_scheduler;
  localparam int INW = 12, OUTW = 32, M = 7, N = 9, MAXK = 8, P = 3, PIPE = 3;
  localparam int KW = $clog2(MAXK+1), AW = $clog2(M*MAXK), BW = $clog2(MAXK*N), CW = $clog2(N+1);

  logic clk = 0, reset = 1, matrices_loaded = 0;
  logic [KW-1:0] K = '0;
  logic [CW-1:0] fifo_capacity = '0;
  logic compute_finished, lane_valid, lane_clear, fifo_wr_en, busy;
  logic [AW-1:0] A_read_addr;
  logic [P*BW-1:0] B_read_addr;
  logic [P*OUTW-1:0] lane_data;
  logic [OUTW-1:0] fifo_data;

  always #5 clk = ~clk;

  mmm_lane_scheduler #(.INW(INW), .OUTW(OUTW), .M(M), .N(N), .MAXK(MAXK), .P(P), .PIPE(PIPE)) dut (
    .clk(clk), .reset(reset), .matrices_loaded(matrices_loaded), .K(K),
    .compute_finished(compute_finished), .A_read_addr(A_read_addr), .B_read_addr(B_read_addr),
    .lane_valid(lane_valid), .lane_clear(lane_clear), .lane_data(lane_data),
    .fifo_capacity(fifo_capacity), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .busy(busy)
  );

  int checks = 0, passes = 0;
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Environment: memories, address history and lane accumulators.
  int amem[64], bmem[128];
  int am[M][MAXK], bm[MAXK][N];
  int acc[P] = '{11, 22, 33};
  int hist_a[PIPE];
  int hist_b[PIPE][P];
  int cyc = 0;

  always_comb for (int l = 0; l < P; l++) lane_data[l*OUTW +: OUTW] = acc[l];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lane_valid)
      for (int l = 0; l < P; l++)
        acc[l] <= (lane_clear ? 0 : acc[l]) + amem[hist_a[PIPE-1]] * bmem[hist_b[PIPE-1][l]];
    for (int j = PIPE-1; j > 0; j--) begin
      hist_a[j] <= hist_a[j-1];
      for (int l = 0; l < P; l++) hist_b[j][l] <= hist_b[j-1][l];
    end
    hist_a[0] <= int'(A_read_addr);
    for (int l = 0; l < P; l++) hist_b[0][l] <= int'(B_read_addr[l*BW +: BW]);
  end

  // Scoreboard monitor.
  int exp_q[$];
  int wr_cnt = 0, cf_cnt = 0, lv_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_wr_en) begin
        wr_cnt++;
        check("wr_cap_nonzero", longint'(fifo_capacity != '0), 1);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_underflow: write of %0d, expected no write", $signed(fifo_data));
        end else check("sb_data", $signed(fifo_data), exp_q.pop_front());
      end
      if (compute_finished) cf_cnt++;
      if (lane_valid) lv_cnt++;
    end
  end

  function automatic int rnd12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cf"}, compute_finished, 0);
    check({tag, "_lv"}, lane_valid, 0);
    check({tag, "_lc"}, lane_clear, 0);
    check({tag, "_wr"}, fifo_wr_en, 0);
    check({tag, "_aaddr"}, A_read_addr, 0);
    check({tag, "_baddr"}, B_read_addr, 0);
    check({tag, "_fdata"}, fifo_data, 0);
  endtask

  // mode 0: free-running, 1: address pattern, 2: stalled drain, 3: random capacity
  task automatic run_matrix(input int kk, input int mode);
    int wr0, cf0, done_n;
    logic [OUTW-1:0] held;
    held = '0;
    for (int r = 0; r < M; r++) for (int k = 0; k < kk; k++) am[r][k] = rnd12();
    for (int k = 0; k < kk; k++) for (int c = 0; c < N; c++) bm[k][c] = rnd12();
    for (int r = 0; r < M; r++) for (int k = 0; k < kk; k++) amem[r*kk + k] = am[r][k];
    for (int k = 0; k < kk; k++) for (int c = 0; c < N; c++) bmem[k*N + c] = bm[k][c];
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < kk; k++) s += am[r][k] * bm[k][c];
        exp_q.push_back(s);
      end
    wr0 = wr_cnt; cf0 = cf_cnt; done_n = -1;
    K = KW'(kk); fifo_capacity = CW'(9); matrices_loaded = 1;
    @(posedge clk); #1 matrices_loaded = 0;
    for (int n = 0; n < 4000 && done_n < 0; n++) begin
      if (mode == 3) fifo_capacity = CW'($urandom_range(0, 2));
      if (mode == 2) fifo_capacity = (n >= 7 && n <= 11) ? CW'(0) : CW'(9);
      @(negedge clk);
      if (mode == 1) begin
        if (n >= 50 && n <= 52) begin
          check("addr_a", A_read_addr, 3 + (n - 50));
          check("addr_b0", B_read_addr[0 +: BW], 6 + 9*(n - 50));
          check("addr_b2", B_read_addr[2*BW +: BW], 8 + 9*(n - 50));
        end
        if (n >= 53 && n <= 55) begin
          check("strobe_valid", lane_valid, 1);
          check("strobe_clear", lane_clear, longint'(n == 53));
        end
        if (n == 56) check("strobe_valid_end", lane_valid, 0);
      end
      if (mode == 2) begin
        if (n == 7) held = fifo_data;
        if (n >= 7 && n <= 11) check("stall_wr", fifo_wr_en, 0);
        if (n >= 8 && n <= 11) check("stall_data", fifo_data, held);
        if (n == 12) check("stall_resume_wr", fifo_wr_en, 1);
      end
      if (compute_finished) done_n = n;
      @(posedge clk); #1;
    end
    if (done_n < 0) begin
      checks++;
      $display("FAIL done_timeout: compute_finished not seen, expected within 4000 cycles");
    end else if (mode == 0) check("done_cycle", done_n, (M*N/P)*(kk + PIPE + 1 + P));
    else if (mode == 2) check("done_cycle_stall", done_n, (M*N/P)*(kk + PIPE + 1 + P) + 5);
    @(negedge clk);
    check("post_done_busy", busy, 0);
    check("post_done_cf", compute_finished, 0);
    repeat (3) @(negedge clk);
    check("write_count", wr_cnt - wr0, M*N);
    check("sb_empty", exp_q.size(), 0);
    check("cf_pulses", cf_cnt - cf0, 1);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lv0, wr0, cf0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check_all_zero("reset");

    // Reset during beat k=1 of the first group abandons it cleanly.
    @(posedge clk); #1;
    K = KW'(3); fifo_capacity = CW'(9); matrices_loaded = 1;
    @(posedge clk); #1 matrices_loaded = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midissue_aaddr", A_read_addr, 1);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check_all_zero("midreset");
    lv0 = lv_cnt; wr0 = wr_cnt;
    repeat (PIPE + 3) @(negedge clk);
    check("midreset_no_lv", lv_cnt - lv0, 0);
    check("midreset_no_wr", wr_cnt - wr0, 0);

    // K=0: straight to DONE; the first IDLE cycle after DONE ignores the start.
    @(posedge clk); #1;
    lv0 = lv_cnt; wr0 = wr_cnt; cf0 = cf_cnt;
    K = '0; matrices_loaded = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("k0_cf", compute_finished, 1);
    check("k0_busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("k0_idle_busy", busy, 0);
    @(posedge clk); #1 matrices_loaded = 0;
    @(negedge clk);
    check("k0_ignore_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("k0_cf_pulses", cf_cnt - cf0, 1);
    check("k0_no_lv", lv_cnt - lv0, 0);
    check("k0_no_wr", wr_cnt - wr0, 0);
    @(posedge clk); #1;

    run_matrix(2, 0);
    run_matrix(3, 1);
    run_matrix(2, 2);
    run_matrix(8, 3);
    run_matrix(1, 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
